// File: rtl/inv_cipher_round_ctrl.sv
// inv_cipher_round_ctrl
// Iterative AES inverse-cipher sequencer (AES-128/192/256 selected by NR).
// Holds the 128-bit cipher state and steps an external inverse-round
// datapath once per clock, walking the round-key index from NR down to 0.
//
// Optional feature, macro INV_CIPHER_BYPASS_EN:
//   when defined, a new ciphertext block may be accepted in the same cycle
//   that the finished plaintext is taken, removing the idle bubble between
//   blocks (throughput NR+1 instead of NR+2 cycles per block).
module inv_cipher_round_ctrl #(
  parameter int NR  = 14,
  parameter int KIW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [127:0]   in_data,
  output logic [KIW-1:0] key_idx,
  input  logic [127:0]   round_key,
  output logic [127:0]   dp_state,
  output logic           dp_last,
  input  logic [127:0]   dp_result,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [127:0]   out_data
);

  // Only the three AES key sizes are meaningful; anything else stops the build.
  generate
    if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
      $error("inv_cipher_round_ctrl: NR must be 10, 12 or 14");
    end
    if (NR >= (1 << KIW)) begin : g_bad_kiw
      $error("inv_cipher_round_ctrl: KIW too narrow to index key NR");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  localparam logic [KIW-1:0] KEY_TOP    = KIW'(NR);
  localparam logic [KIW-1:0] KEY_TOP_M1 = KIW'(NR - 1);

  fsm_t           fsm;
  fsm_t           fsm_nxt;
  logic [KIW-1:0] rnd;
  logic [KIW-1:0] rnd_nxt;
  logic [127:0]   blk;
  logic [127:0]   blk_nxt;

  // The cipher state feeds both the datapath and the plaintext output.
  assign dp_state = blk;
  assign out_data = blk;

  // State, round counter and cipher state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm <= IDLE;
      rnd <= '0;
      blk <= '0;
    end else begin
      fsm <= fsm_nxt;
      rnd <= rnd_nxt;
      blk <= blk_nxt;
    end
  end

  // Next-state, counter/register updates and handshake outputs.
  always_comb begin
    fsm_nxt   = fsm;
    rnd_nxt   = rnd;
    blk_nxt   = blk;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    dp_last   = 1'b0;
    key_idx   = KEY_TOP;

    case (fsm)
      IDLE: begin
        in_ready = 1'b1;
        key_idx  = KEY_TOP;
        if (in_valid) begin
          blk_nxt = in_data ^ round_key;
          rnd_nxt = KEY_TOP_M1;
          fsm_nxt = RUN;
        end
      end

      RUN: begin
        key_idx = rnd;
        dp_last = (rnd == '0);
        blk_nxt = dp_result;
        if (rnd == '0) begin
          fsm_nxt = DONE;
        end else begin
          rnd_nxt = rnd - 1'b1;
        end
      end

      DONE: begin
        out_valid = 1'b1;
`ifdef INV_CIPHER_BYPASS_EN
        in_ready = out_ready;
        key_idx  = KEY_TOP;
        if (out_ready) begin
          if (in_valid) begin
            blk_nxt = in_data ^ round_key;
            rnd_nxt = KEY_TOP_M1;
            fsm_nxt = RUN;
          end else begin
            fsm_nxt = IDLE;
          end
        end
`else
        key_idx = '0;
        if (out_ready) begin
          fsm_nxt = IDLE;
        end
`endif
      end

      default: begin
        fsm_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_inv_cipher_round_ctrl.sv
// tb_inv_cipher_round_ctrl
// Self-checking bench: supplies the round-key store and inverse-round
// datapath behaviourally, and compares the sequencer against FIPS-197
// known answers and a whole-block decryption model.
// Honours INV_CIPHER_BYPASS_EN the same way as the design.
module tb_inv_cipher_round_ctrl;

  localparam int NR  = 14;
  localparam int KIW = 4;
  localparam int NK  = NR - 6;
`ifdef INV_CIPHER_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  localparam logic [127:0] KAT_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KAT_CT =
    (NR == 10) ? 128'h69c4e0d86a7b0430d8cdb78070b4c55a :
    (NR == 12) ? 128'hdda97ca4864cdfe06eaf70a0ec0d7191 :
                 128'h8ea2b7ca516745bfeafc49904b496089;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic [127:0]   in_data = '0;
  logic           in_ready;
  logic           out_valid;
  logic           dp_last;
  logic [KIW-1:0] key_idx;
  logic [127:0]   round_key;
  logic [127:0]   dp_state;
  logic [127:0]   dp_result;
  logic [127:0]   out_data;

  int checks = 0;
  int passed = 0;

  logic [7:0]   sbox     [256];
  logic [7:0]   inv_sbox [256];
  logic [31:0]  w        [4*(NR+1)];
  logic [127:0] rk       [1<<KIW];

  inv_cipher_round_ctrl #(.NR(NR), .KIW(KIW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .key_idx   (key_idx),
    .round_key (round_key),
    .dp_state  (dp_state),
    .dp_last   (dp_last),
    .dp_result (dp_result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  // GF(2^8) multiply with the AES polynomial.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box entry from the field inverse and the affine transform.
  function automatic logic [7:0] sbox_calc(input logic [7:0] a);
    logic [7:0] b;
    b = 8'h01;
    if (a == 8'h00) b = 8'h00;
    else for (int i = 0; i < 254; i++) b = gmul(b, a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] t);
    return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
  endfunction

  // One inverse round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
  function automatic logic [127:0] inv_round(input logic [127:0] s,
                                             input logic [127:0] k,
                                             input logic last);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        b[4*c+r] = inv_sbox[a[4*((c - r + 4) % 4) + r]] ^ k[127-8*(4*c+r) -: 8];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = b[4*c]; a1 = b[4*c+1]; a2 = b[4*c+2]; a3 = b[4*c+3];
      if (last) o[127-32*c -: 32] = {a0, a1, a2, a3};
      else o[127-32*c -: 32] = {
        gmul(a0,8'h0e) ^ gmul(a1,8'h0b) ^ gmul(a2,8'h0d) ^ gmul(a3,8'h09),
        gmul(a0,8'h09) ^ gmul(a1,8'h0e) ^ gmul(a2,8'h0b) ^ gmul(a3,8'h0d),
        gmul(a0,8'h0d) ^ gmul(a1,8'h09) ^ gmul(a2,8'h0e) ^ gmul(a3,8'h0b),
        gmul(a0,8'h0b) ^ gmul(a1,8'h0d) ^ gmul(a2,8'h09) ^ gmul(a3,8'h0e)};
    end
    return o;
  endfunction

  // Whole-block reference decryption with the expanded key.
  function automatic logic [127:0] ref_decrypt(input logic [127:0] ct);
    logic [127:0] s;
    s = ct ^ rk[NR];
    for (int r = NR - 1; r >= 0; r--) s = inv_round(s, rk[r], r == 0);
    return s;
  endfunction

  // Key store and datapath seen by the sequencer.
  always_comb begin
    round_key = rk[key_idx];
    dp_result = inv_round(dp_state, round_key, dp_last);
  end

  task automatic init_tables();
    logic [31:0] t;
    logic [7:0]  rcon;
    for (int i = 0; i < 256; i++) sbox[i] = sbox_calc(8'(i));
    for (int i = 0; i < 256; i++) inv_sbox[sbox[i]] = 8'(i);
    rcon = 8'h01;
    for (int i = 0; i < 4*(NR+1); i++) begin
      if (i < NK) begin
        w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
      end else begin
        t = w[i-1];
        if (i % NK == 0) begin
          t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h000000};
          rcon = gmul(rcon, 8'h02);
        end else if (NK > 6 && i % NK == 4) begin
          t = sub_word(t);
        end
        w[i] = w[i-NK] ^ t;
      end
    end
    for (int r = 0; r < (1 << KIW); r++)
      rk[r] = (r <= NR) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); else passed++;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); else passed++;
    checks++; if (key_idx !== KIW'(NR)) $display("[TB] FAIL reset_key_idx: got %0d expected %0d", key_idx, NR); else passed++;
    checks++; if (dp_state !== 128'h0) $display("[TB] FAIL reset_dp_state: got %h expected 0", dp_state); else passed++;
    checks++; if (dp_last !== 1'b0) $display("[TB] FAIL reset_dp_last: got %b expected 0", dp_last); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_known_answer();
    logic [KIW-1:0] exp_key;
    in_data = KAT_CT; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL kat_in_ready: got %b expected 1", in_ready); else passed++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= NR + 1; k++) begin
      @(negedge clk);
      exp_key = (k <= NR) ? KIW'(NR - k) : (BYPASS ? KIW'(NR) : KIW'(0));
      checks++; if (key_idx !== exp_key) $display("[TB] FAIL kat_key_idx T+%0d: got %0d expected %0d", k, key_idx, exp_key); else passed++;
      checks++; if (dp_last !== (k == NR)) $display("[TB] FAIL kat_dp_last T+%0d: got %b expected %b", k, dp_last, (k == NR)); else passed++;
      checks++; if (out_valid !== (k == NR + 1)) $display("[TB] FAIL kat_out_valid T+%0d: got %b expected %b", k, out_valid, (k == NR + 1)); else passed++;
      checks++; if (in_ready !== 1'b0) $display("[TB] FAIL kat_busy_in_ready T+%0d: got %b expected 0", k, in_ready); else passed++;
      if (k == NR + 1) begin
        checks++; if (out_data !== KAT_PT) $display("[TB] FAIL kat_out_data: got %h expected %h", out_data, KAT_PT); else passed++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    in_data = KAT_CT ^ 128'h1; in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) $display("[TB] FAIL bp_out_valid cyc %0d: got %b expected 1", i, out_valid); else passed++;
      checks++; if (out_data !== KAT_PT) $display("[TB] FAIL bp_out_data cyc %0d: got %h expected %h", i, out_data, KAT_PT); else passed++;
      checks++; if (in_ready !== 1'b0) $display("[TB] FAIL bp_in_ready cyc %0d: got %b expected 0", i, in_ready); else passed++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL bp_idle_in_ready: got %b expected 1", in_ready); else passed++;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL bp_idle_out_valid: got %b expected 0", out_valid); else passed++;
    checks++; if (key_idx !== KIW'(NR)) $display("[TB] FAIL bp_idle_key_idx: got %0d expected %0d", key_idx, NR); else passed++;
    checks++; if (dp_state !== KAT_PT) $display("[TB] FAIL bp_idle_held_state: got %h expected %h", dp_state, KAT_PT); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int acc_cyc[$];
    logic [127:0] outs[$];
    int cyc;
    int exp_gap;
    exp_gap = BYPASS ? NR + 1 : NR + 2;
    cyc = 0;
    in_data = KAT_CT; in_valid = 1'b1; out_ready = 1'b1;
    while ((acc_cyc.size() < 4 || outs.size() < 4) && cyc < 200) begin
      @(negedge clk);
      if (in_valid && in_ready) acc_cyc.push_back(cyc);
      if (out_valid && out_ready) outs.push_back(out_data);
      @(posedge clk); #1;
      if (acc_cyc.size() >= 4) in_valid = 1'b0;
      cyc++;
    end
    checks++;
    if (acc_cyc.size() != 4 || outs.size() != 4)
      $display("[TB] FAIL b2b_count: got %0d accepts %0d outputs expected 4 and 4", acc_cyc.size(), outs.size());
    else passed++;
    for (int i = 1; i < acc_cyc.size(); i++) begin
      checks++;
      if (acc_cyc[i] - acc_cyc[i-1] != exp_gap)
        $display("[TB] FAIL b2b_gap %0d: got %0d expected %0d", i, acc_cyc[i] - acc_cyc[i-1], exp_gap);
      else passed++;
    end
    for (int i = 0; i < outs.size(); i++) begin
      checks++; if (outs[i] !== KAT_PT) $display("[TB] FAIL b2b_data %0d: got %h expected %h", i, outs[i], KAT_PT); else passed++;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int ov_seen;
    int cyc;
    bit got;
    logic [127:0] captured;
    in_data = KAT_CT; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (key_idx !== KIW'(NR - 6)) $display("[TB] FAIL mid_key_idx: got %0d expected %0d", key_idx, NR - 6); else passed++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL mid_in_ready: got %b expected 1", in_ready); else passed++;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL mid_out_valid: got %b expected 0", out_valid); else passed++;
    checks++; if (key_idx !== KIW'(NR)) $display("[TB] FAIL mid_idle_key_idx: got %0d expected %0d", key_idx, NR); else passed++;
    checks++; if (dp_state !== 128'h0) $display("[TB] FAIL mid_dp_state: got %h expected 0", dp_state); else passed++;
    ov_seen = 0;
    for (int i = 0; i < 2 * NR; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (out_valid) ov_seen++;
    end
    checks++; if (ov_seen != 0) $display("[TB] FAIL mid_no_output: got %0d out_valid cycles expected 0", ov_seen); else passed++;
    @(posedge clk); #1;
    in_data = KAT_CT; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    got = 1'b0; cyc = 0; captured = '0;
    while (!got && cyc < 4 * NR) begin
      @(negedge clk);
      if (out_valid) begin got = 1'b1; captured = out_data; end
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (!got) $display("[TB] FAIL post_reset_done: got timeout expected out_valid"); else passed++;
    checks++; if (captured !== KAT_PT) $display("[TB] FAIL post_reset_data: got %h expected %h", captured, KAT_PT); else passed++;
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [127:0] exp_q[$];
    int acc_q[$];
    int cyc, got, lat;
    bit pending, prev_ov, prev_stall;
    logic [127:0] prev_data, exp_pt;
    cyc = 0; got = 0; pending = 1'b0; prev_ov = 1'b0; prev_stall = 1'b0; prev_data = '0;
    while (got < 8 && cyc < 1500) begin
      if (!pending) begin
        pending = ($urandom_range(0, 3) != 0);
        if (pending) in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      in_valid = pending;
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_decrypt(in_data));
        acc_q.push_back(cyc);
        pending = 1'b0;
      end
      if (out_valid && !prev_ov) begin
        lat = (acc_q.size() > 0) ? cyc - acc_q.pop_front() : -1;
        checks++; if (lat != NR + 1) $display("[TB] FAIL rnd_latency: got %0d expected %0d", lat, NR + 1); else passed++;
      end
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== prev_data)
          $display("[TB] FAIL rnd_hold: got valid %b data %h expected valid 1 data %h", out_valid, out_data, prev_data);
        else passed++;
      end
      if (out_valid && out_ready) begin
        exp_pt = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
        checks++; if (out_data !== exp_pt) $display("[TB] FAIL rnd_data %0d: got %h expected %h", got, out_data, exp_pt); else passed++;
        got++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
      prev_ov = out_valid;
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (got != 8) $display("[TB] FAIL rnd_count: got %0d outputs expected 8", got); else passed++;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (2 * NR) @(posedge clk);
    #1;
  endtask

  initial begin
    init_tables();
    $display("[TB] inv_cipher_round_ctrl NR=%0d bypass=%0d", NR, BYPASS);
    test_reset();
    test_known_answer();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
